// File: rtl/fir_pkg.sv
// Shared definitions for the transposed-form FIR core: state encoding,
// bus map defaults, control bit positions and output scaling.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fir_state_t;

  localparam logic [17:0] COEF_BASE_DEF  = 18'h03000;
  localparam logic [17:0] CTRL_ADDR_DEF  = 18'h03010;
  localparam int          CTRL_START_BIT = 0;
  localparam int          CTRL_ABORT_BIT = 1;

  // Truncating shift by the coefficient fraction, then clamp to a 16-bit result.
  function automatic logic signed [15:0] shift_sat(input logic signed [63:0] acc,
                                                   input int frac_bits);
    logic signed [63:0] shifted;
    shifted = acc >>> frac_bits;
    if (shifted > 64'sd32767) return 16'sh7fff;
    if (shifted < -64'sd32768) return 16'sh8000;
    return shifted[15:0];
  endfunction

endpackage

// File: rtl/fir_bus_if.sv
// Avalon-style write bus shared by the sample ROM loader and the FIR core.
interface fir_bus_if;
  logic        write;
  logic [17:0] address;
  logic [15:0] writedata;

  modport master (output write, output address, output writedata);
  modport slave  (input write, input address, input writedata);
endinterface

// File: rtl/fir_tap.sv
// One transposed-form tap: coefficient register, its product with the current
// sample, and the partial-sum register fed by the next tap up the chain.
module fir_tap
  import fir_pkg::*;
#(
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    coef_we,
  input  logic signed [15:0]      coef_wdata,
  input  logic                    clear,
  input  logic                    accept,
  input  logic signed [15:0]      x,
  input  logic signed [ACC_W-1:0] z_in,
  output logic signed [ACC_W-1:0] z_out
);

  logic signed [15:0]      h_q, h_d;
  logic signed [ACC_W-1:0] z_q, z_d;
  logic signed [31:0]      prod;

  assign prod  = h_q * x;
  assign z_out = z_q;

  always_comb begin
    h_d = h_q;
    z_d = z_q;
    if (coef_we) h_d = coef_wdata;
    if (clear) z_d = '0;
    else if (accept) z_d = z_in + {{(ACC_W-32){prod[31]}}, prod};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q <= '0;
      z_q <= '0;
    end else begin
      h_q <= h_d;
      z_q <= z_d;
    end
  end

endmodule

// File: rtl/fir_transposed_core.sv
// Streaming transposed-form FIR behind the sample ROM: run-control FSM,
// request pipeline, tap chain and saturated output register.
module fir_transposed_core
  import fir_pkg::*;
#(
  parameter int          TAPS        = 8,
  parameter int          NUM_SAMPLES = 2001,
  parameter logic [17:0] COEF_BASE   = COEF_BASE_DEF,
  parameter logic [17:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter int          FRAC_BITS   = 15
) (
  input  logic               clk,
  input  logic               reset,
  fir_bus_if.slave           bus,
  input  logic signed [15:0] sample_in,
  output logic               sample_req,
  output logic signed [15:0] y_out,
  output logic               y_valid,
  output logic               busy,
  output logic               done
);

  localparam int ACC_W = 32 + $clog2(TAPS);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int DRN_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(NUM_SAMPLES);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(TAPS - 2);

  fir_state_t         state_q, state_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
  logic               req_d1_q, req_d1_d;
  logic signed [15:0] h0_q, h0_d;
  logic signed [15:0] y_out_q, y_out_d;
  logic               y_valid_q, y_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic                    ctrl_hit, abort, start, accept, clear_z, coef_hit;
  logic [17:0]             coef_off;
  logic signed [15:0]      x;
  logic signed [31:0]      p0;
  logic signed [ACC_W-1:0] acc;
  logic signed [63:0]      acc_ext;
  logic signed [ACC_W-1:0] z [TAPS-1];

  assign ctrl_hit   = bus.write && (bus.address == CTRL_ADDR);
  assign abort      = ctrl_hit && bus.writedata[CTRL_ABORT_BIT];
  assign start      = ctrl_hit && !abort && bus.writedata[CTRL_START_BIT] && !busy_q;
  assign coef_off   = bus.address - COEF_BASE;
  assign coef_hit   = bus.write && (coef_off < 18'(TAPS)) && !busy_q;
  assign clear_z    = abort || start;
  // The ROM freezes readdata on write cycles, so any bus write stalls the request.
  assign sample_req = (state_q == ST_RUN) && !bus.write && (req_cnt_q < REQ_LAST);
  assign accept     = !abort && (((state_q == ST_RUN) && req_d1_q) || (state_q == ST_DRAIN));
  assign x          = (state_q == ST_DRAIN) ? 16'sd0 : sample_in;

  assign p0      = h0_q * x;
  assign acc     = {{(ACC_W-32){p0[31]}}, p0} + z[0];
  assign acc_ext = {{(64-ACC_W){acc[ACC_W-1]}}, acc};

  for (genvar i = 0; i < TAPS - 1; i++) begin : g_tap
    logic signed [ACC_W-1:0] z_next;
    if (i == TAPS - 2) begin : g_last
      assign z_next = '0;
    end else begin : g_mid
      assign z_next = z[i+1];
    end
    fir_tap #(.ACC_W(ACC_W)) u_tap (
      .clk        (clk),
      .reset      (reset),
      .coef_we    (coef_hit && (coef_off == 18'(i + 1))),
      .coef_wdata (bus.writedata),
      .clear      (clear_z),
      .accept     (accept),
      .x          (x),
      .z_in       (z_next),
      .z_out      (z[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    drn_cnt_d = drn_cnt_q;
    req_d1_d  = sample_req;
    h0_d      = h0_q;
    y_out_d   = y_out_q;
    y_valid_d = accept;
    if (coef_hit && (coef_off == 18'd0)) h0_d = bus.writedata;
    if (accept) y_out_d = shift_sat(acc_ext, FRAC_BITS);
    if (abort) begin
      state_d   = ST_IDLE;
      req_d1_d  = 1'b0;
      req_cnt_d = '0;
      drn_cnt_d = '0;
    end else if (start) begin
      state_d   = ST_RUN;
      req_cnt_d = '0;
      drn_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (sample_req) req_cnt_d = req_cnt_q + CNT_W'(1);
          // The cycle after the final request carries its acceptance.
          if ((req_cnt_q == REQ_LAST) && req_d1_q) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          drn_cnt_d = drn_cnt_q + DRN_W'(1);
          if (drn_cnt_q == DRN_LAST) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      req_cnt_q <= '0;
      drn_cnt_q <= '0;
      req_d1_q  <= 1'b0;
      h0_q      <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      req_d1_q  <= req_d1_d;
      h0_q      <= h0_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fir_transposed_core.sv
// Scoreboard bench for fir_transposed_core: a behavioural ROM feeds the core and a
// direct-form reference filter predicts every y_out.
module tb_fir_transposed_core;

  localparam int          TAPS      = 8;
  localparam int          NUM       = 16;
  localparam logic [17:0] COEF_BASE = 18'h03000;
  localparam logic [17:0] CTRL_ADDR = 18'h03010;
  localparam logic [17:0] ROM_ADDR  = 18'h00040;

  logic               clk;
  logic               reset;
  logic signed [15:0] sample_in = '0;
  logic               sample_req;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               busy;
  logic               done;

  fir_bus_if busIf ();

  fir_transposed_core #(
    .TAPS        (TAPS),
    .NUM_SAMPLES (NUM),
    .COEF_BASE   (COEF_BASE),
    .CTRL_ADDR   (CTRL_ADDR),
    .FRAC_BITS   (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (busIf),
    .sample_in  (sample_in),
    .sample_req (sample_req),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .busy       (busy),
    .done       (done)
  );

  int                 checkCount = 0;
  int                 failCount  = 0;
  int                 pulseTotal = 0;
  int                 pulseBase  = 0;
  longint             expQ[$];
  logic signed [15:0] hModel [TAPS];
  logic signed [15:0] romMem [256];
  int                 romPtr = 0;
  logic               romRewind;
  logic               monitorOn;
  logic               timingOn;
  logic [1:0]         reqHist = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM: registered readdata, pointer advances on each request.
  always @(posedge clk) begin
    if (romRewind) romPtr <= 0;
    else if (sample_req) begin
      sample_in <= romMem[romPtr & 255];
      romPtr    <= romPtr + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Output monitor: pops the scoreboard and checks the two-cycle request latency.
  always @(negedge clk) begin
    if (reset && monitorOn && y_valid) begin
      pulseTotal++;
      if (expQ.size() == 0) checkOutput("extraValid", y_valid, 0);
      else checkOutput("yOut", y_out, expQ.pop_front());
    end
    if (reset && timingOn) begin
      if (reqHist[1]) checkOutput("validLatency", y_valid, 1);
      reqHist = {reqHist[0], sample_req};
    end else begin
      reqHist = 2'b00;
    end
  end

  task automatic busWrite(input logic [17:0] addr, input logic [15:0] data);
    busIf.write     = 1'b1;
    busIf.address   = addr;
    busIf.writedata = data;
    @(posedge clk); #1;
    busIf.write = 1'b0;
  endtask

  task automatic setCoef(input int k, input logic [15:0] value);
    busWrite(COEF_BASE + 18'(k), value);
    hModel[k] = value;
  endtask

  task automatic rewindRom();
    romRewind = 1'b1;
    @(posedge clk); #1;
    romRewind = 1'b0;
  endtask

  // Direct-form reference: y[n] = sum h[k]*x[n-k], x zero outside the run.
  task automatic pushExpected();
    longint acc;
    for (int n = 0; n < NUM + TAPS - 1; n++) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++)
        if ((n - k >= 0) && (n - k < NUM))
          acc += longint'(hModel[k]) * longint'(romMem[n - k]);
      acc = acc >>> 15;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      expQ.push_back(acc);
    end
  endtask

  task automatic applyStimulus();
    pushExpected();
    pulseBase = pulseTotal;
    busWrite(CTRL_ADDR, 16'h0001);
  endtask

  task automatic runToDone(input bit stallOn, input logic [17:0] stallAddr);
    int reqCount;
    bit finished;
    bit stallNow;
    reqCount = 0;
    finished = 0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      stallNow = stallOn && (cyc % 5 == 3) && (cyc < 24);
      if (stallNow) begin
        busIf.write     = 1'b1;
        busIf.address   = stallAddr;
        busIf.writedata = 16'h7fff;
      end
      @(negedge clk);
      if (cyc == 0) begin
        checkOutput("startBusy", busy, 1);
        checkOutput("startReq", sample_req, 1);
      end
      if (stallNow) checkOutput("stallReq", sample_req, 0);
      if (sample_req) reqCount++;
      if (done) finished = 1;
      @(posedge clk); #1;
      busIf.write = 1'b0;
    end
    checkOutput("runDone", finished, 1);
    checkOutput("reqCount", reqCount, NUM);
    @(negedge clk);
    checkOutput("doneHeld", done, 1);
    checkOutput("busyIdle", busy, 0);
    checkOutput("validCount", pulseTotal - pulseBase, NUM + TAPS - 1);
    checkOutput("queueEmpty", expQ.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Req"}, sample_req, 0);
    checkOutput({tag, "Y"}, y_out, 0);
    checkOutput({tag, "Valid"}, y_valid, 0);
    checkOutput({tag, "Busy"}, busy, 0);
    checkOutput({tag, "Done"}, done, 0);
  endtask

  initial begin
    int seen;
    reset           = 1'b0;
    busIf.write     = 1'b0;
    busIf.address   = '0;
    busIf.writedata = '0;
    romRewind       = 1'b1;
    monitorOn       = 1'b1;
    timingOn        = 1'b1;
    for (int k = 0; k < TAPS; k++) hModel[k] = '0;
    for (int i = 0; i < 256; i++) romMem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("rst");
    reset     = 1'b1;
    romRewind = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single-tap gain");
    for (int k = 0; k < TAPS; k++) setCoef(k, (k == 0) ? 16'h4000 : 16'h0000);
    for (int i = 0; i < NUM; i++) romMem[i] = 16'h2000;
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);

    $display("[TB] impulse response");
    for (int k = 0; k < TAPS; k++) setCoef(k, 16'(1000 * k));
    for (int i = 0; i < NUM; i++) romMem[i] = (i == 0) ? 16'h4000 : 16'h0000;
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);

    $display("[TB] saturation");
    for (int k = 0; k < TAPS; k++) setCoef(k, 16'h7fff);
    for (int i = 0; i < NUM; i++) romMem[i] = 16'h7fff;
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);
    for (int i = 0; i < NUM; i++) romMem[i] = 16'h8000;
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);

    $display("[TB] random data, plain then stalled");
    for (int k = 0; k < TAPS; k++) setCoef(k, 16'($urandom_range(0, 8191)) - 16'd4096);
    for (int i = 0; i < NUM; i++) romMem[i] = 16'($urandom_range(0, 65535));
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);
    rewindRom();
    applyStimulus();
    runToDone(1, ROM_ADDR);

    $display("[TB] coefficient writes while busy");
    rewindRom();
    applyStimulus();
    runToDone(1, COEF_BASE + 18'd2);
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);

    $display("[TB] abort and restart");
    rewindRom();
    applyStimulus();
    repeat (6) begin
      @(posedge clk); #1;
    end
    monitorOn = 1'b0;
    timingOn  = 1'b0;
    busWrite(CTRL_ADDR, 16'h0003);
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortReq", sample_req, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abortNoValid", y_valid, 0);
      @(posedge clk); #1;
    end
    checkOutput("abortDone", done, 0);
    expQ.delete();
    monitorOn = 1'b1;
    timingOn  = 1'b1;
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);

    $display("[TB] reset during drain");
    rewindRom();
    applyStimulus();
    seen = 0;
    for (int cyc = 0; cyc < 100 && seen < NUM; cyc++) begin
      @(negedge clk);
      if (sample_req) seen++;
      @(posedge clk); #1;
    end
    checkOutput("drainReqs", seen, NUM);
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("drainBusy", busy, 1);
    monitorOn = 1'b0;
    timingOn  = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkAllZero("midRst");
    @(posedge clk); #1;
    reset = 1'b1;
    expQ.delete();
    for (int k = 0; k < TAPS; k++) hModel[k] = '0;
    monitorOn = 1'b1;
    timingOn  = 1'b1;
    rewindRom();
    applyStimulus();
    runToDone(0, ROM_ADDR);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
